// File: rtl/decode_queue.sv
// decode_queue: decodes each incoming RV32I(+custom I/O) instruction and
// stores the decoded fields in a DEPTH-entry circular buffer.
// Optional build macro: DECODE_QUEUE_MULDIV_EN adds the M-extension operators.
// Ports:
//   clk, rst (async active-high), flush
//   in_valid/in_ready, in_instruction, in_pc       -- raw instruction input
//   out_valid/out_ready, out_pc, out_rs1/rs2/rd_address, out_imm,
//   out_alu_operator, out_operand1_src, out_operand2_src, out_pc_operand1_src,
//   out_next_pc_src, out_reg_write_data_src, side-effect enables, out_illegal
// Select encodings:
//   operand1_src    0=RS1 1=PC 2=ZERO
//   operand2_src    0=RS2 1=IMM
//   pc_operand1_src 0=PC  1=RS1 (jump/branch target base)
//   next_pc_src     0=PC+4 1=branch if ALU zero 2=branch if ALU nonzero 3=jump
//   reg_write_data_src 0=ALU 1=RAM 2=PC+4 3=STDIN
module decode_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1_address,
    output logic [4:0]  out_rs2_address,
    output logic [4:0]  out_rd_address,
    output logic [31:0] out_imm,
    output logic [4:0]  out_alu_operator,
    output logic [1:0]  out_operand1_src,
    output logic [2:0]  out_operand2_src,
    output logic        out_pc_operand1_src,
    output logic [1:0]  out_next_pc_src,
    output logic [1:0]  out_reg_write_data_src,
    output logic        out_reg_write_enable,
    output logic        out_ram_write_enable,
    output logic        out_stdin_read_enable,
    output logic        out_stdout_write_enable,
    output logic        out_illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IO     = 7'b0001011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [2:0] SRC2_RS2  = 3'd0;
    localparam logic [2:0] SRC2_IMM  = 3'd1;
    localparam logic [1:0] NPC_SEQ   = 2'd0;
    localparam logic [1:0] NPC_BZ    = 2'd1;
    localparam logic [1:0] NPC_BNZ   = 2'd2;
    localparam logic [1:0] NPC_JUMP  = 2'd3;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_RAM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;
    localparam logic [1:0] WB_STDIN  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic        pc_op1;
        logic [1:0]  next_pc;
        logic [1:0]  wb;
        logic        reg_we;
        logic        ram_we;
        logic        stdin_re;
        logic        stdout_we;
        logic        illegal;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            dec;
    entry_t            head_e;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              push, pop, bad;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_iz, imm_s, imm_b, imm_j, imm_u;

    assign opcode = in_instruction[6:0];
    assign funct3 = in_instruction[14:12];
    assign funct7 = in_instruction[31:25];
    assign imm_i  = {{20{in_instruction[31]}}, in_instruction[31:20]};
    assign imm_iz = {20'b0, in_instruction[31:20]};
    assign imm_s  = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
    assign imm_b  = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                     in_instruction[30:25], in_instruction[11:8], 1'b0};
    assign imm_j  = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                     in_instruction[20], in_instruction[30:21], 1'b0};
    assign imm_u  = {in_instruction[31:12], 12'b0};

    // funct3 -> operator for the shared OP / OP-IMM table (funct7 variants handled by caller)
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.pc  = in_pc;
        dec.rs1 = in_instruction[19:15];
        dec.rs2 = in_instruction[24:20];
        dec.rd  = in_instruction[11:7];
        case (opcode)
            OP_LUI: begin
                dec.imm = imm_u; dec.op1 = SRC1_ZERO; dec.op2 = SRC2_IMM; dec.reg_we = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = imm_u; dec.op1 = SRC1_PC; dec.op2 = SRC2_IMM; dec.reg_we = 1'b1;
            end
            OP_JAL: begin
                dec.imm = imm_j; dec.next_pc = NPC_JUMP; dec.wb = WB_PC4; dec.reg_we = 1'b1;
            end
            OP_JALR: begin
                dec.imm = imm_i; dec.pc_op1 = 1'b1; dec.next_pc = NPC_JUMP;
                dec.wb = WB_PC4; dec.reg_we = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm = imm_b;
                case (funct3)
                    3'b000:  begin dec.alu = ALU_SUB;  dec.next_pc = NPC_BZ;  end
                    3'b001:  begin dec.alu = ALU_SUB;  dec.next_pc = NPC_BNZ; end
                    3'b100:  begin dec.alu = ALU_SLT;  dec.next_pc = NPC_BNZ; end
                    3'b101:  begin dec.alu = ALU_SLT;  dec.next_pc = NPC_BZ;  end
                    3'b110:  begin dec.alu = ALU_SLTU; dec.next_pc = NPC_BNZ; end
                    3'b111:  begin dec.alu = ALU_SLTU; dec.next_pc = NPC_BZ;  end
                    default: bad = 1'b1;
                endcase
            end
            // memory is word-wide only: LW / SW
            OP_LOAD: begin
                dec.imm = imm_i; dec.op2 = SRC2_IMM; dec.wb = WB_RAM; dec.reg_we = 1'b1;
                bad = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec.imm = imm_s; dec.op2 = SRC2_IMM; dec.ram_we = 1'b1;
                bad = (funct3 != 3'b010);
            end
            OP_IMM: begin
                dec.op2 = SRC2_IMM; dec.reg_we = 1'b1; dec.alu = base_alu(funct3);
                dec.imm = imm_i;
                case (funct3)
                    3'b001: begin dec.imm = imm_iz; bad = (funct7 != 7'b0000000); end
                    3'b011: dec.imm = imm_iz;
                    3'b101: begin
                        dec.imm = imm_iz;
                        if (funct7 == 7'b0100000) dec.alu = ALU_SRA;
                        else bad = (funct7 != 7'b0000000);
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                dec.reg_we = 1'b1;
                case (funct7)
                    7'b0000000: dec.alu = base_alu(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.alu = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu = ALU_SRA;
                        else                       bad = 1'b1;
                    end
`ifdef DECODE_QUEUE_MULDIV_EN
                    7'b0000001: dec.alu = 5'd10 + {2'b00, funct3};
`endif
                    default: bad = 1'b1;
                endcase
            end
            OP_IO: begin
                case (funct3)
                    3'b000:  begin dec.reg_we = 1'b1; dec.stdin_re = 1'b1; dec.wb = WB_STDIN; end
                    3'b001:  dec.stdout_we = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // illegal entries carry a fixed, harmless field set rather than partial decode
        if (bad) begin
            dec.imm       = '0;
            dec.alu       = ALU_ADD;
            dec.op1       = SRC1_RS1;
            dec.op2       = SRC2_RS2;
            dec.pc_op1    = 1'b0;
            dec.next_pc   = NPC_SEQ;
            dec.wb        = WB_ALU;
            dec.reg_we    = 1'b0;
            dec.ram_we    = 1'b0;
            dec.stdin_re  = 1'b0;
            dec.stdout_we = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= dec;
                tail      <= ptr_next(tail);
            end
            if (pop) head <= ptr_next(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head_e                  = mem[head];
    assign out_pc                  = head_e.pc;
    assign out_rs1_address         = head_e.rs1;
    assign out_rs2_address         = head_e.rs2;
    assign out_rd_address          = head_e.rd;
    assign out_imm                 = head_e.imm;
    assign out_alu_operator        = head_e.alu;
    assign out_operand1_src        = head_e.op1;
    assign out_operand2_src        = head_e.op2;
    assign out_pc_operand1_src     = head_e.pc_op1;
    assign out_next_pc_src         = head_e.next_pc;
    assign out_reg_write_data_src  = head_e.wb;
    assign out_reg_write_enable    = head_e.reg_we;
    assign out_ram_write_enable    = head_e.ram_we;
    assign out_stdin_read_enable   = head_e.stdin_re;
    assign out_stdout_write_enable = head_e.stdout_we;
    assign out_illegal             = head_e.illegal;

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered decoded-instruction entries (legal range 1..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), occupancy counter width.
REQ-003 SHALL have one clock and an asynchronous active-high reset, as listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 flush  in  1  discard all buffered entries and the current input.
REQ-007 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-008 in_instruction / in_pc  in  32 / 32  raw instruction and its address.
REQ-009 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-010 out_pc  out  32  address of the head entry.
REQ-011 out_rs1_address, out_rs2_address, out_rd_address  out  5 each  register fields.
REQ-012 out_imm  out  32  sign-/zero-extended immediate.
REQ-013 out_alu_operator  out  5  ALU operation.
REQ-014 out_operand1_src / out_operand2_src / out_pc_operand1_src  out  2 / 3 / 1  ALU operand selects.
REQ-015 out_next_pc_src / out_reg_write_data_src  out  2 / 2  PC and writeback selects.
REQ-016 out_reg_write_enable, out_ram_write_enable, out_stdin_read_enable, out_stdout_write_enable  out  1 each  side-effect enables.
REQ-017 out_illegal  out  1  head entry is an undecodable instruction.

Function
REQ-018 Decode SHALL be combinational on in_instruction; the result SHALL be written into a DEPTH-entry circular buffer on the accepting edge (in_valid && in_ready && !flush).
REQ-019 Every decoded field SHALL have a defined value for every opcode/funct combination; no field holds a stale value.
REQ-020 ALU operator encoding: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-021 Immediates: I signed; SLLI/SRLI/SRAI/SLTIU zero-extended imm[11:0]; S, B (bit0=0), J (bit0=0) signed; U = {imm[31:12], 12'b0}.
REQ-022 Custom opcode 0001011: funct3 000 = stdin (reg write, stdin_read_enable=1), funct3 001 = stdout (stdout_write_enable=1, no reg write).
REQ-023 Unrecognised opcode, funct3 or funct7 SHALL set out_illegal=1 with all four enables 0, next_pc_src not-branch, alu_operator ADD.
REQ-024 Latency: entry accepted at edge N SHALL be visible with out_valid=1 after edge N when buffer was empty; no combinational in-to-out path.
REQ-025 in_ready SHALL equal (count < DEPTH), registered-state only; no dependence on out_ready.
REQ-026 out_valid SHALL equal (count != 0); head pops on out_valid && out_ready.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; head and tail pointers each advance and wrap from DEPTH-1 to 0.
REQ-028 Output fields SHALL hold constant while out_valid && !out_ready.
REQ-029 flush SHALL, on the next edge, zero count and both pointers; a concurrent push or pop SHALL be ignored; out_valid=0 and in_ready=1 after that edge.

Reset
REQ-030 rst SHALL asynchronously clear count, pointers and all storage to 0; out_valid=0, in_ready=1, all out_* fields 0.
REQ-031 rst asserted mid-transfer SHALL lose all buffered entries; first acceptance occurs on the first edge after rst deasserts.

Configuration
REQ-032 Macro DECODE_QUEUE_MULDIV_EN defined: opcode 0110011 with funct7 0000001 SHALL decode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to operators 10..17 (funct3 order), operands RS1/RS2, reg write enabled.
REQ-033 Macro undefined: those encodings SHALL decode as illegal per REQ-023.

Verification
REQ-034 Push 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, operator ADD, operand2 IMM, reg_write_enable=1, out_illegal=0.
REQ-035 DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after second accept, third held; raise out_ready -> entries drain in order, in_ready returns to 1.
REQ-036 Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, operator SUB, next_pc_src branch-on-zero, reg_write_enable=0.
REQ-037 Fill buffer, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not delivered.
REQ-038 Push 0xFFFFFFFF -> out_illegal=1, all enables 0; push 0x02208033 -> operator 10 with DECODE_QUEUE_MULDIV_EN, out_illegal=1 without.
REQ-039 Steady push+pop with out_ready=1 over 3*DEPTH cycles -> count constant at 1, pointer wrap, pc sequence preserved.
